// File: rtl/seq_mul_param.sv
// seq_mul_param: sequential shift-and-add multiplier with start/done handshake.
// Multiplies magnitudes one multiplier bit per cycle, then fixes the sign.
// The loop exits as soon as the remaining multiplier bits are all zero.
//
// State table:
//   state    | meaning
//   S_IDLE   | waiting for i_start; o_done high when no request pending
//   S_LOAD   | capture operand magnitudes and product sign
//   S_STEP   | one shift-and-add iteration per cycle
//   S_FIX    | negate the accumulator if the product is negative
//   S_FINISH | register result halves and overflow, raise o_done
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   i_start      request, sampled only in S_IDLE
//   i_is_signed  two's-complement operands, sampled with i_start
//   i_a, i_b     multiplicand / multiplier, sampled in S_LOAD
//   o_result     low WIDTH bits of the product
//   o_result_hi  high WIDTH bits of the product
//   o_overflow   product does not fit in o_result
//   o_done       result valid / block idle
//   o_busy       high whenever the FSM is not in S_IDLE
module seq_mul_param #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_overflow,
    output logic             o_done,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_FIX,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic               r_sgn;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_mplier_shr;
    logic [WIDTH-1:0]   w_acc_hi;
    logic               w_ovf;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
    // as an unsigned number, so no extra bit is needed.
    assign w_mag_a      = (r_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b      = (r_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_mplier_shr = r_mplier >> 1;
    assign w_acc_hi     = r_acc[2*WIDTH-1:WIDTH];
    assign w_ovf        = r_sgn ? (w_acc_hi != {WIDTH{r_acc[WIDTH-1]}})
                                : (w_acc_hi != '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = i_start ? S_LOAD : S_IDLE;
            S_LOAD:   w_state_next = (w_mag_b != '0) ? S_STEP : S_FIX;
            S_STEP:   w_state_next = (w_mplier_shr == '0) ? S_FIX : S_STEP;
            S_FIX:    w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        o_busy = (r_state != S_IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_sgn       <= 1'b0;
            o_result    <= '0;
            o_result_hi <= '0;
            o_overflow  <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        o_done <= 1'b0;
                        r_sgn  <= i_is_signed & SIGNED_EN;
                    end else begin
                        o_done <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                    r_mplier <= w_mag_b;
                    r_neg    <= r_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                    r_acc    <= '0;
                end
                S_STEP: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                end
                S_FIX: begin
                    // Negating zero yields zero, so a zero product is never negative.
                    if (r_neg) begin
                        r_acc <= -r_acc;
                    end
                end
                S_FINISH: begin
                    o_result    <= r_acc[WIDTH-1:0];
                    o_result_hi <= w_acc_hi;
                    o_overflow  <= w_ovf;
                    o_done      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_param.sv
// tb_seq_mul_param: scoreboard bench for seq_mul_param (WIDTH=32).
// Two instances share operands: one honours is_signed, one has it disabled.
// Stimulus pushes expected products (from plain integer arithmetic) into a
// queue per instance; monitors pop and compare when a product completes.
module tb_seq_mul_param;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [W-1:0] result0, result_hi0, result1, result_hi1;
    logic         overflow0, done0, busy0, overflow1, done1, busy1;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic prev_busy0 = 1'b0;
    logic prev_busy1 = 1'b0;

    seq_mul_param #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut_s (
        .clk        (clk),
        .reset      (reset),
        .i_start    (start0),
        .i_is_signed(is_signed),
        .i_a        (a),
        .i_b        (b),
        .o_result   (result0),
        .o_result_hi(result_hi0),
        .o_overflow (overflow0),
        .o_done     (done0),
        .o_busy     (busy0)
    );

    seq_mul_param #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
        .clk        (clk),
        .reset      (reset),
        .i_start    (start1),
        .i_is_signed(is_signed),
        .i_a        (a),
        .i_b        (b),
        .o_result   (result1),
        .o_result_hi(result_hi1),
        .o_overflow (overflow1),
        .o_done     (done1),
        .o_busy     (busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer product, overflow by range, latency from |b|.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic sgn, input int e0);
        exp_t         e;
        longint       ps;
        longint       lim;
        logic [63:0]  pu;
        logic [W-1:0] mag_b;
        int           k;
        if (sgn) begin
            ps    = longint'($signed(ma)) * longint'($signed(mb));
            lim   = longint'(1) << (W - 1);
            pu    = ps;
            e.ovf = (ps >= lim) || (ps < -lim);
            mag_b = mb[W-1] ? -mb : mb;
        end else begin
            pu    = {32'b0, ma} * {32'b0, mb};
            e.ovf = (pu > 64'h0000_0000_FFFF_FFFF);
            mag_b = mb;
        end
        e.lo = pu[31:0];
        e.hi = pu[63:32];
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (mag_b[i]) k = i + 1;
        end
        e.done_cyc = e0 + k + 3;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && prev_busy0 && done0) begin
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL s_unexpected: got result %0h with no request pending", result0);
            end else begin
                e = q0.pop_front();
                chk("s_result", result0, e.lo);
                chk("s_result_hi", result_hi0, e.hi);
                chk("s_overflow", overflow0, e.ovf);
                chk("s_done_cycle", cyc, e.done_cyc);
            end
        end
        prev_busy0 = busy0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && prev_busy1 && done1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL u_unexpected: got result %0h with no request pending", result1);
            end else begin
                e = q1.pop_front();
                chk("u_result", result1, e.lo);
                chk("u_result_hi", result_hi1, e.hi);
                chk("u_overflow", overflow1, e.ovf);
                chk("u_done_cycle", cyc, e.done_cyc);
            end
        end
        prev_busy1 = busy1;
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(done0 && !busy0 && done1 && !busy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy %0b/%0b expected idle", busy0, busy1);
        end
    endtask

    // Starts both instances on the same edge; returns the start edge index.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic s, output int e0);
        wait_idle();
        a         = ia;
        b         = ib;
        is_signed = s;
        start0    = 1'b1;
        start1    = 1'b1;
        e0        = cyc + 1;
        q0.push_back(model(ia, ib, s, e0));
        q1.push_back(model(ia, ib, 1'b0, e0));
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        chk("busy_after_start", {busy0, busy1}, 2'b11);
    endtask

    initial begin
        int   e0;
        exp_t e;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("reset_result", {result0, result_hi0}, 64'h0);
        chk("reset_flags", {overflow0, done0, busy0}, 3'b000);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_done", {done0, done1}, 2'b11);

        issue(32'd7, 32'd6, 1'b0, e0);
        wait_cyc(e0 + 5);
        chk("busy_last_cycle", busy0, 1'b1);
        issue(-32'sd3, 32'd5, 1'b1, e0);
        issue(32'd123, 32'd0, 1'b1, e0);
        issue(32'd123, 32'd0, 1'b0, e0);
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, e0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, e0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, e0);
        issue(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, e0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, e0);

        // Start pulsed while busy, with different operands: must be ignored.
        issue(32'h0000_1234, 32'h0000_00FF, 1'b0, e0);
        wait_cyc(e0 + 1);
        a      = 32'hDEAD_BEEF;
        b      = 32'h0000_0003;
        start0 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_idle();

        // Reset in the middle of an operation aborts it.
        issue(32'h0000_0005, 32'h0000_FFFF, 1'b0, e0);
        wait_cyc(e0 + 2);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("abort_result", {result0, result_hi0}, 64'h0);
        chk("abort_flags", {overflow0, done0, busy0, done1, busy1}, 5'b00000);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_done", {done0, busy0, done1, busy1}, 4'b1010);
        chk("abort_result_kept", {result0, result_hi0, result1}, 96'h0);

        // start held high: two back-to-back products on the signed instance.
        wait_idle();
        a         = 32'h0000_0009;
        b         = 32'hFFFF_FFFE;
        is_signed = 1'b1;
        start0    = 1'b1;
        e0        = cyc + 1;
        e = model(a, b, 1'b1, e0);
        q0.push_back(e);
        q0.push_back(model(a, b, 1'b1, e.done_cyc + 1));
        wait_cyc(e.done_cyc);
        chk("b2b_done_high", done0, 1'b1);
        wait_cyc(e.done_cyc + 1);
        chk("b2b_done_drop", {done0, busy0}, 2'b01);
        start0 = 1'b0;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom_range(0, 255);
                1: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'h0;
                1: rb = $urandom_range(0, 1023);
                2: rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: rb = $urandom;
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), e0);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("queues_drained", q0.size() + q1.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
